mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for a multiply-class op.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for a divide-class op.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1 bit, a one-cycle request from the E stage to issue Op.
REQ-006 SHALL have port Op, input, 4 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes are no-ops.
REQ-007 SHALL have ports A and B, input, 32 bits each: A is the rs operand and B the rt operand.
REQ-008 SHALL have port Flush, input, 1 bit, an exception or interrupt cancel from CP0.
REQ-009 SHALL have port Busy, output, 1 bit, high while a multi-cycle op is in flight.
REQ-010 SHALL have ports HI and LO, output, 32 bits each, the architectural HI/LO registers feeding the LOHI path.

Function
REQ-011 SHALL implement an FSM with exactly two states: IDLE and RUN.
REQ-012 SHALL accept Start only in IDLE with Flush low; a Start in RUN or with Flush high SHALL be ignored and change no state.
REQ-013 For accepted MTHI/MTLO, SHALL write A into HI/LO at that same edge, stay IDLE, and keep Busy low.
REQ-014 For accepted multiply-class ops, SHALL latch A, B and Op, load the down-counter with MULT_CYCLES, and enter RUN.
REQ-015 For accepted divide-class ops, SHALL do the same as REQ-014 but load the counter with DIV_CYCLES.
REQ-016 SHALL assert Busy for exactly N cycles following the accepting edge (N = loaded count); the hazard unit stalls D on Busy|Start.
REQ-017 At the edge where the counter reaches zero, SHALL write HI/LO, return to IDLE and drop Busy; new values are visible in the first cycle Busy is low.
REQ-018 MULT/MULTU: {HI,LO} SHALL be the 64-bit signed/unsigned product of A and B.
REQ-019 DIV/DIVU: LO SHALL be the quotient truncated toward zero and HI the remainder carrying the sign of the dividend.
REQ-020 For signed DIV 0x80000000 / 0xFFFFFFFF, SHALL produce LO=0x80000000 and HI=0.
REQ-021 On divide by zero, SHALL leave HI/LO unchanged while still spending DIV_CYCLES in RUN.
REQ-022 Flush during RUN SHALL NOT abort the op, because the op is already committed past E.
REQ-023 HI/LO SHALL hold their value in all cycles other than the write edges of REQ-013 and REQ-017.
REQ-024 Operands used for computation SHALL be the latched copies; A, B and Op changes during RUN have no effect.

Reset
REQ-025 While reset is high at a clock edge, SHALL force state IDLE, counter 0, Busy 0, HI 0, LO 0.
REQ-026 Reset during RUN SHALL discard the in-flight op with no HI/LO write.
REQ-027 Reset concurrent with Start SHALL win, so Start is ignored.

Configuration
REQ-028 Macro MDU_MADD_EN SHALL gate multiply-accumulate support.
REQ-029 With MDU_MADD_EN defined, ops 6-9 SHALL behave like multiply-class ops, with {HI,LO} = {HI,LO} ± product (signed for 6/8, unsigned for 7/9), mod 2^64, using HI/LO as sampled at the accepting edge.
REQ-030 Without MDU_MADD_EN, ops 6-9 SHALL be treated as no-ops, and no accumulate adder SHALL be synthesized.

Verification
REQ-031 Reset, then MULT A=0xFFFFFFFE, B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU of same operands -> LO=0x7FFFFFFC, HI=1.
REQ-033 MTLO A=0x1234 in IDLE -> LO=0x1234 next cycle, Busy never high; DIV by B=0 after that -> Busy 10 cycles, LO stays 0x1234.
REQ-034 MULT issued, then Start MTHI with A=5 during RUN -> MTHI ignored, so HI equals the product high word; also Start with Flush=1 in IDLE -> Busy stays 0.
REQ-035 Reset asserted at RUN cycle 3 of a DIV -> Busy 0, HI=LO=0 next cycle, with no later write.
REQ-036 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro, same stimulus leaves HI/LO unchanged and Busy 0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers plus a fixed-latency RUN phase.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 6-9).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic is_mul_cls;
    logic is_div_cls;
    logic accept;

    // Decode of the incoming op
    always_comb begin
        is_div_cls = (Op == OP_DIV) || (Op == OP_DIVU);
        is_mul_cls = (Op == OP_MULT) || (Op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul_cls = is_mul_cls || (Op == OP_MADD) || (Op == OP_MADDU)
                                || (Op == OP_MSUB) || (Op == OP_MSUBU);
`endif
        accept = (state_q == IDLE) && Start && !Flush;
    end

    logic        mul_signed;
    logic        div_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] res;
    logic        res_we;

    // Result datapath, driven only by the latched operands
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        a_ext = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;

        // Magnitude division sidesteps the signed overflow of 0x80000000 / -1
        div_signed = (op_q == OP_DIV);
        a_neg = div_signed && a_q[31];
        b_neg = div_signed && b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;
        den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

        res    = {hi_q, lo_q};
        res_we = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res    = prod;
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res    = {rem, quot};
                res_we = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                res    = {hi_q, lo_q} + prod;
                res_we = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                res    = {hi_q, lo_q} - prod;
                res_we = 1'b1;
            end
`endif
            default: begin
                res    = {hi_q, lo_q};
                res_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end else if (is_mul_cls || is_div_cls) begin
                        op_d    = Op;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = is_div_cls ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Flush is deliberately ignored here: the op already left E
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (res_we) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
